// File: rtl/branch_predictor.sv
// Fetch-side bimodal predictor with a direct-mapped BTB, plus decode-stage
// misprediction detection, redirect generation and resolution statistics.
module branch_predictor #(
    parameter int          IDX_BITS = 6,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_PC,
    output logic        IF_PredTaken,
    output logic [31:0] IF_PredPC,
    input  logic        ID_ResolveValid,
    input  logic [31:0] ID_PC,
    input  logic        ID_PredTaken,
    input  logic [31:0] ID_PredPC,
    input  logic        ID_ActualTaken,
    input  logic [31:0] ID_Target,
    input  logic        PCWrite,
    output logic        branch_mispredicted,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == 2'b11) nxt = 2'b11;
            else              nxt = ctr + 2'b01;
        end else begin
            if (ctr == 2'b00) nxt = 2'b00;
            else              nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

    logic [1:0]          bht_q       [ENTRIES];
    logic                btb_valid_q [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q   [ENTRIES];
    logic [31:0]         btb_tgt_q   [ENTRIES];
    logic [31:0]         stat_branches_q;
    logic [31:0]         stat_mispredicts_q;
    logic [31:0]         stat_branches_d;
    logic [31:0]         stat_mispredicts_d;

    logic [IDX_BITS-1:0] if_idx_s;
    logic [TAG_BITS-1:0] if_tag_s;
    logic                if_hit_s;
    logic                pred_taken_s;
    logic [31:0]         pred_pc_s;

    logic [IDX_BITS-1:0] id_idx_s;
    logic [TAG_BITS-1:0] id_tag_s;
    logic                mispredict_s;
    logic                upd_en_s;
    logic [1:0]          bht_d;
    logic [31:0]         redirect_s;

    // Fetch lookup: reads only registered state, so a same-cycle update is not seen.
    always_comb begin
        if_idx_s     = IF_PC[IDX_BITS+1:2];
        if_tag_s     = IF_PC[31:IDX_BITS+2];
        if_hit_s     = btb_valid_q[if_idx_s] && (btb_tag_q[if_idx_s] == if_tag_s);
        pred_taken_s = if_hit_s && bht_q[if_idx_s][1];
        if (pred_taken_s) begin
            pred_pc_s = btb_tgt_q[if_idx_s];
        end else begin
            pred_pc_s = IF_PC + 32'd4;
        end
    end

    // Decode resolution: mispredict is reported even while stalled.
    always_comb begin
        id_idx_s     = ID_PC[IDX_BITS+1:2];
        id_tag_s     = ID_PC[31:IDX_BITS+2];
        mispredict_s = ID_ResolveValid &&
                       ((ID_PredTaken != ID_ActualTaken) ||
                        (ID_ActualTaken && (ID_PredPC != ID_Target)));
        if (ID_ActualTaken) begin
            redirect_s = ID_Target;
        end else begin
            redirect_s = ID_PC + 32'd4;
        end
    end

    // Next-state for the counter and statistics; gated by PCWrite so a stalled branch counts once.
    always_comb begin
        upd_en_s = ID_ResolveValid && PCWrite;
        bht_d    = ctr_step(bht_q[id_idx_s], ID_ActualTaken);
        if (upd_en_s) begin
            stat_branches_d    = stat_branches_q + 32'd1;
            stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict_s};
        end else begin
            stat_branches_d    = stat_branches_q;
            stat_mispredicts_d = stat_mispredicts_q;
        end
    end

    // Table and statistics state; reset clears every entry in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i]       <= CTR_INIT;
                btb_valid_q[i] <= 1'b0;
            end
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            if (upd_en_s) begin
                bht_q[id_idx_s] <= bht_d;
                if (ID_ActualTaken) begin
                    btb_valid_q[id_idx_s] <= 1'b1;
                    btb_tag_q[id_idx_s]   <= id_tag_s;
                    btb_tgt_q[id_idx_s]   <= ID_Target;
                end
            end
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign IF_PredTaken        = pred_taken_s;
    assign IF_PredPC           = pred_pc_s;
    assign branch_mispredicted = mispredict_s;
    assign redirect_pc         = redirect_s;
    assign stat_branches       = stat_branches_q;
    assign stat_mispredicts    = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] IF_PC;
    logic        IF_PredTaken;
    logic [31:0] IF_PredPC;
    logic        ID_ResolveValid;
    logic [31:0] ID_PC;
    logic        ID_PredTaken;
    logic [31:0] ID_PredPC;
    logic        ID_ActualTaken;
    logic [31:0] ID_Target;
    logic        PCWrite;
    logic        branch_mispredicted;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int vectors;
    int miscompares;

    branch_predictor dut (
        .clk                 (clk),
        .reset               (reset),
        .IF_PC               (IF_PC),
        .IF_PredTaken        (IF_PredTaken),
        .IF_PredPC           (IF_PredPC),
        .ID_ResolveValid     (ID_ResolveValid),
        .ID_PC               (ID_PC),
        .ID_PredTaken        (ID_PredTaken),
        .ID_PredPC           (ID_PredPC),
        .ID_ActualTaken      (ID_ActualTaken),
        .ID_Target           (ID_Target),
        .PCWrite             (PCWrite),
        .branch_mispredicted (branch_mispredicted),
        .redirect_pc         (redirect_pc),
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge, then let new inputs settle before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic v, input logic [31:0] pc, input logic pt,
                           input logic [31:0] ppc, input logic at, input logic [31:0] tgt,
                           input logic pcw);
        ID_ResolveValid = v;
        ID_PC           = pc;
        ID_PredTaken    = pt;
        ID_PredPC       = ppc;
        ID_ActualTaken  = at;
        ID_Target       = tgt;
        PCWrite         = pcw;
        #1;
    endtask

    task automatic idle();
        resolve(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic predict(input string tag, input logic [31:0] pc,
                           input logic exp_t, input logic [31:0] exp_pc);
        IF_PC = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, IF_PredTaken}, {31'd0, exp_t});
        chk({tag, "_pc"}, IF_PredPC, exp_pc);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        IF_PC       = 32'h0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Cleared state
        predict("rst_pred", 32'h100, 1'b0, 32'h104);
        chk("rst_sb", stat_branches, 32'd0);
        chk("rst_sm", stat_mispredicts, 32'd0);
        chk("rst_mis", {31'd0, branch_mispredicted}, 32'd0);

        // First taken resolve: mispredicted, trains counter 01->10 and BTB
        resolve(1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80, 1'b1);
        chk("first_mis", {31'd0, branch_mispredicted}, 32'd1);
        chk("first_redir", redirect_pc, 32'h80);
        tick();
        idle();
        predict("trained", 32'h100, 1'b1, 32'h80);
        chk("first_sb", stat_branches, 32'd1);
        chk("first_sm", stat_mispredicts, 32'd1);

        // Four correct taken resolves: counter saturates at 11
        for (int k = 0; k < 4; k++) begin
            resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1);
            chk("ok_mis", {31'd0, branch_mispredicted}, 32'd0);
            tick();
        end
        idle();
        chk("sat_sb", stat_branches, 32'd5);
        chk("sat_sm", stat_mispredicts, 32'd1);

        // Not-taken mispredict held through 3 stall cycles then released: one step (11->10)
        resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h80, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_mis", {31'd0, branch_mispredicted}, 32'd1);
            chk("stall_redir", redirect_pc, 32'h104);
            tick();
        end
        chk("stall_sb", stat_branches, 32'd5);
        PCWrite = 1'b1;
        #1;
        chk("rel_mis", {31'd0, branch_mispredicted}, 32'd1);
        tick();
        idle();
        predict("one_step", 32'h100, 1'b1, 32'h80);
        chk("rel_sb", stat_branches, 32'd6);
        chk("rel_sm", stat_mispredicts, 32'd2);

        // JALR with wrong target: redirect, BTB retargeted, counter 10->11
        resolve(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1);
        chk("jalr_mis", {31'd0, branch_mispredicted}, 32'd1);
        chk("jalr_redir", redirect_pc, 32'h90);
        tick();
        idle();
        predict("retarget", 32'h100, 1'b1, 32'h90);
        chk("jalr_sm", stat_mispredicts, 32'd3);

        // Same-cycle lookup and update at 0x204: lookup sees pre-update state
        resolve(1'b1, 32'h204, 1'b0, 32'h208, 1'b1, 32'h300, 1'b1);
        predict("same_cyc", 32'h204, 1'b0, 32'h208);
        tick();
        idle();
        predict("next_cyc", 32'h204, 1'b1, 32'h300);

        // Alias with tag mismatch misses
        predict("alias", 32'h1100, 1'b0, 32'h1104);

        // Valid low suppresses mispredict; not-taken keeps BTB but decrements 10->01
        resolve(1'b0, 32'h204, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        chk("novalid_mis", {31'd0, branch_mispredicted}, 32'd0);
        resolve(1'b1, 32'h204, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        chk("nt_redir", redirect_pc, 32'h208);
        tick();
        idle();
        predict("nt_dec", 32'h204, 1'b0, 32'h208);
        chk("nt_sb", stat_branches, 32'd9);
        chk("nt_sm", stat_mispredicts, 32'd5);

        // Reset mid-operation with an update pending: history and stats dropped
        resolve(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        predict("post_rst", 32'h100, 1'b0, 32'h104);
        predict("post_rst2", 32'h204, 1'b0, 32'h208);
        chk("post_rst_sb", stat_branches, 32'd0);

        // Floor saturation: NT, NT (01->00->00), then T, T (->01->10) predicts taken
        resolve(1'b1, 32'h100, 1'b0, 32'h104, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        resolve(1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80, 1'b1);
        tick();
        idle();
        predict("floor_one", 32'h100, 1'b0, 32'h104);
        resolve(1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80, 1'b1);
        tick();
        idle();
        predict("floor_two", 32'h100, 1'b1, 32'h80);
        chk("floor_sb", stat_branches, 32'd4);
        chk("floor_sm", stat_mispredicts, 32'd2);

        // 32-bit wrap of PC+4 on both sides
        predict("wrap_pred", 32'hFFFF_FFFC, 1'b0, 32'h0);
        resolve(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 32'h40, 1'b0);
        chk("wrap_redir", redirect_pc, 32'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
